// File: rtl/seq_det_moore_fsm.sv
// seq_det_moore_fsm: Moore detector for the serial pattern 1-0-1-1.
// Define SEQ_DET_MATCH_CNT_EN to add a saturating 8-bit match counter.
module seq_det_moore_fsm #(
  parameter int OVERLAP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sequence_in,
`ifdef SEQ_DET_MATCH_CNT_EN
  output logic [7:0] match_count,
`endif
  output logic       detector_out
);

  typedef enum logic [2:0] {
    S_ZERO = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_t;

  localparam logic OVL = (OVERLAP != 0);

  state_t state_q;
  state_t state_d;

  // state register, async clear to idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; illegal codes recover to idle
  always_comb begin
    state_d = S_ZERO;
    unique case (state_q)
      S_ZERO: state_d = sequence_in ? S_1 : S_ZERO;
      S_1:    state_d = sequence_in ? S_1 : S_10;
      S_10:   state_d = sequence_in ? S_101 : S_ZERO;
      S_101:  state_d = sequence_in ? S_1011 : S_10;
      S_1011: begin
        if (sequence_in) begin
          state_d = S_1;
        end else begin
          state_d = OVL ? S_10 : S_ZERO;
        end
      end
      default: state_d = S_ZERO;
    endcase
  end

  // output decoded from registered state only
  assign detector_out = (state_q == S_1011);

`ifdef SEQ_DET_MATCH_CNT_EN
  // count matches, saturate at 255
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_count <= 8'd0;
    end else if (state_d == S_1011 && match_count != 8'hFF) begin
      match_count <= match_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_moore_fsm.sv
// tb_seq_det_moore_fsm: vector table, corner sequences and random
// stimulus against a bit-history reference model.
module tb_seq_det_moore_fsm;

  logic clock;
  logic reset;
  logic sequence_in;
  logic det_ov;
  logic det_nv;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [7:0] cnt_ov;
  logic [7:0] cnt_nv;
`endif

  int checks = 0;
  int errors = 0;

  seq_det_moore_fsm #(.OVERLAP(1)) u_ov (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_count  (cnt_ov),
`endif
    .detector_out (det_ov)
  );

  seq_det_moore_fsm #(.OVERLAP(0)) u_nv (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_count  (cnt_nv),
`endif
    .detector_out (det_nv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: bit history since reset (or since last match
  // when not overlapping); a match is the last four bits == 1011
  logic [3:0] h_ov, h_nv;
  int v_ov, v_nv;
  logic e_ov, e_nv;
  int mc_ov, mc_nv;

  task automatic m_reset();
    h_ov = '0; h_nv = '0;
    v_ov = 0; v_nv = 0;
    e_ov = 1'b0; e_nv = 1'b0;
    mc_ov = 0; mc_nv = 0;
  endtask

  task automatic m_clock(input logic b);
    h_ov = {h_ov[2:0], b};
    h_nv = {h_nv[2:0], b};
    v_ov = (v_ov < 4) ? v_ov + 1 : 4;
    v_nv = (v_nv < 4) ? v_nv + 1 : 4;
    e_ov = (v_ov >= 4) && (h_ov == 4'b1011);
    e_nv = (v_nv >= 4) && (h_nv == 4'b1011);
    if (e_ov && mc_ov < 255) mc_ov++;
    if (e_nv && mc_nv < 255) mc_nv++;
    if (e_nv) v_nv = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " det_ov"}, int'(det_ov), int'(e_ov));
    chk({tag, " det_nv"}, int'(det_nv), int'(e_nv));
`ifdef SEQ_DET_MATCH_CNT_EN
    chk({tag, " cnt_ov"}, int'(cnt_ov), mc_ov);
    chk({tag, " cnt_nv"}, int'(cnt_nv), mc_nv);
`endif
  endtask

  // drive at negedge, clock once, return at next negedge
  task automatic step(input logic b, input logic r);
    reset = r;
    sequence_in = b;
    if (!r) m_reset();
    @(posedge clock);
    if (r) m_clock(b);
    @(negedge clock);
  endtask

  typedef struct packed {
    logic rst;
    logic in;
    logic eo;
    logic en;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic i,
                     input logic eo, input logic en);
    vec_t v;
    v.rst = r; v.in = i; v.eo = eo; v.en = en;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    sequence_in = 1'b0;
    m_reset();

    // single match
    add(1,0,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(0,1,0,0); add(0,1,1,1); add(0,0,0,0); add(0,0,0,0);
    // overlap vs non-overlap
    add(1,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,1,1,1);
    add(0,0,0,0); add(0,1,0,0); add(0,1,1,0);
    // near misses
    add(1,1,0,0); add(0,0,0,0); add(0,0,0,0); add(0,1,0,0);
    add(0,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,0,0,0);
    add(1,1,0,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0);
    add(0,1,1,1);

    @(negedge clock);

    // reset held with input toggling
    step(1, 0); chk("rst hold ov", int'(det_ov), 0);
    chk("rst hold nv", int'(det_nv), 0);
    step(0, 0); chk("rst hold ov", int'(det_ov), 0);
    step(1, 0); chk("rst hold ov", int'(det_ov), 0);
    chk_model("rst");
    // from S_ZERO, "11" cannot complete a match
    step(1, 1); chk("post rst b1", int'(det_ov), 0);
    step(1, 1); chk("post rst b2", int'(det_ov), 0);
    chk_model("post rst");

    // table vectors
    foreach (tbl[k]) begin
      if (tbl[k].rst) step(1'b0, 1'b0);
      step(tbl[k].in, 1'b1);
      chk($sformatf("vec%0d ov", k), int'(det_ov), int'(tbl[k].eo));
      chk($sformatf("vec%0d nv", k), int'(det_nv), int'(tbl[k].en));
    end

    // reset while output high drops it immediately
    step(0, 0);
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    chk("pulse ov", int'(det_ov), 1);
    chk("pulse nv", int'(det_nv), 1);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("async drop ov", int'(det_ov), 0);
    chk("async drop nv", int'(det_nv), 0);
    @(negedge clock);

    // mid-sequence reset discards partial 101
    step(1, 1); step(0, 1); step(1, 1);
    #2 reset = 1'b0;
    m_reset();
    @(negedge clock);
    step(1, 1);
    chk("mid rst ov", int'(det_ov), 0);
    chk("mid rst nv", int'(det_nv), 0);
    chk_model("mid rst");

`ifdef SEQ_DET_MATCH_CNT_EN
    // counter saturation
    step(0, 0);
    for (int n = 0; n < 300; n++) begin
      step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    end
    chk("cnt sat", int'(cnt_ov), 255);
    chk_model("cnt sat");
    step(0, 1);
    chk("cnt hold", int'(cnt_ov), 255);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("cnt clr", int'(cnt_ov), 0);
    chk("cnt clr nv", int'(cnt_nv), 0);
    @(negedge clock);
`endif

    // randomized stimulus with occasional resets
    step(0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic b;
      logic r;
      b = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 199) != 0);
      step(b, r);
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_moore_fsm.md
Name: seq_det_moore_fsm

Overview:
- Serial bit-stream sequence detector built as a Moore FSM; detects the pattern 1-0-1-1, oldest bit first.
- Samples one input bit per rising clock edge.
- Output is a function of the registered state only, so it is glitch-free and safe to feed other synchronous logic directly.
- Sits at the leaf level behind any serial receiver or bit-slicer that presents one qualified bit per clock.

Parameters:
- OVERLAP, default 1, 1 = overlapping detection (suffix of a match may start the next match); 0 = non-overlapping (FSM restarts after a match).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; 0 forces the FSM to S_ZERO immediately
- sequence_in  input  1  serial data bit, sampled on each rising edge of clock
- detector_out  output  1  high while the FSM is in S_1011 (pattern just completed)

Behaviour:
- State encoding: 3-bit state register; states S_ZERO=0, S_1=1, S_10=2, S_101=3, S_1011=4; codes 5-7 are illegal and fall back to S_ZERO on the next edge.
- Reset: reset=0 asynchronously forces state to S_ZERO and detector_out to 0. Reset released (reset=1) synchronously to the next edge. Reset asserted mid-sequence discards the partial match.
- Transitions (in=sequence_in):
  - S_ZERO: in=1 -> S_1; in=0 -> S_ZERO
  - S_1: in=1 -> S_1; in=0 -> S_10
  - S_10: in=1 -> S_101; in=0 -> S_ZERO
  - S_101: in=1 -> S_1011; in=0 -> S_10
  - S_1011, OVERLAP=1: in=1 -> S_1; in=0 -> S_10
  - S_1011, OVERLAP=0: in=1 -> S_1; in=0 -> S_ZERO
- Output: detector_out = (state == S_1011). No combinational path from sequence_in to detector_out.
- Latency: the edge that samples the final 1 moves the FSM to S_1011. detector_out rises after that edge and stays high for exactly one clock period, since S_1011 is never re-entered directly.
- Back-to-back matches are impossible closer than 3 cycles apart (1011011 with OVERLAP=1 gives two pulses 3 cycles apart).
- X/Z on sequence_in is not handled; the driver guarantees a known value at each sampled edge.

Optional Feature:
- Macro SEQ_DET_MATCH_CNT_EN.
- Defined:
  - Adds output port match_count, 8 bits.
  - The counter increments by 1 on every edge where the next state is S_1011.
  - It saturates at 255 (no wrap).
  - reset=0 clears it asynchronously to 0.
- Not defined:
  - Port and counter are absent.
  - Detection behaviour is identical in both builds.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with sequence_in toggling -> detector_out=0 throughout; on release, FSM is in S_ZERO.
- Single match: after reset, feed 0,0,1,0,1,1,0,0 one bit per cycle -> detector_out high for exactly one cycle, in the cycle after the 6th bit (second 1 of "11") is sampled; low otherwise.
- Overlap, OVERLAP=1: feed 1,0,1,1,0,1,1 -> two one-cycle pulses, after bit 4 and after bit 7. With OVERLAP=0 the same stream gives one pulse, after bit 4.
- Near-misses: feed 1,0,0,1,1,1,1,0 -> detector_out never asserts; 1,1,0,1,1 -> one pulse after bit 5.
- Mid-sequence reset: feed 1,0,1, assert reset=0 asynchronously between edges, release, then feed 1 -> no pulse. detector_out drops to 0 immediately if reset is asserted while it is high.
- Counter (SEQ_DET_MATCH_CNT_EN): feed 1011 repeated 300 times -> match_count reaches 255 and holds; reset=0 returns it to 0.
